clk_divider_prog: RTL and testbench
===================================

Name: clk_divider_prog

Overview:
Runtime-programmable clock divider. Generalises the fixed half-rate toggler: the divide count is a parameter-width register loaded at run time, with an enable and a load handshake. New divide values are applied glitch-free at period boundaries. Drives the sample-rate and waveform-step enables of the signal generator. It produces a 50%-duty divided clock plus a one-cycle TICK strobe for logic clocked on CLOCK.

Parameters:
CNT_WIDTH, 26, width of divide counter and DIV_VALUE.
DEFAULT_DIV, 0, divide value loaded at reset; must be < 2^CNT_WIDTH.

Ports:
CLOCK  input  1  system clock; all logic on its rising edge.
RESET_N  input  1  synchronous active-low reset.
ENABLE  input  1  1 = run, 0 = hold divider idle.
DIV_VALUE  input  CNT_WIDTH  requested divide value N; output half-period = N+1 CLOCK cycles.
DIV_LOAD  input  1  one-cycle strobe; captures DIV_VALUE.
DIV_CLOCK  output  1  divided clock, period 2*(N+1) CLOCK cycles, 50% duty.
TICK  output  1  one-cycle pulse in the cycle DIV_CLOCK is 1 for the first time in a period.
LOAD_PENDING  output  1  1 while a captured value awaits application.

Behaviour:
- Reset (RESET_N = 0 at a rising edge), one edge, overrides all other inputs:
  - COUNT = 0, DIV_CLOCK = 0, TICK = 0.
  - LOAD_PENDING = 0, active divide = DEFAULT_DIV, pending register = 0.
- States:
  - IDLE (ENABLE = 0): COUNT held at 0, DIV_CLOCK = 0, TICK = 0. Active divide and any pending value are retained.
  - RUN (ENABLE = 1): runs every edge.
- RUN, each edge:
  - If COUNT == active N: COUNT <= 0 and DIV_CLOCK toggles.
  - Otherwise: COUNT <= COUNT+1.
- TICK <= 1 exactly when DIV_CLOCK toggles 0 -> 1; else 0.
- Latency from IDLE: ENABLE first sampled high at edge k -> DIV_CLOCK = 1 and TICK = 1 after edge k+N.
- ENABLE falling mid-period: at the next edge, COUNT = 0, DIV_CLOCK = 0, TICK = 0. No partial pulse is stretched.
- Load handshake:
  - DIV_LOAD = 1 at an edge: DIV_VALUE goes into the pending register and LOAD_PENDING <= 1.
  - A later DIV_LOAD before the value is applied overwrites the pending value (last write wins).
- Application point:
  - RUN: the pending value is applied only at the edge where DIV_CLOCK toggles 1 -> 0 (end of a full period). The active divide takes the pending value, LOAD_PENDING <= 0, COUNT <= 0.
  - No period ever mixes two divide values; duty stays exactly 50%.
  - IDLE: a pending value is applied at the next edge.
- DIV_LOAD in the same cycle as an application edge: the incoming DIV_VALUE is applied directly and LOAD_PENDING stays 0.
- N = 0: DIV_CLOCK toggles every edge (CLOCK/2); TICK is high every second cycle.
- N = 2^CNT_WIDTH-1: COUNT reaches the all-ones value and wraps to 0 via the terminal compare, never via overflow.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro DIV_PERIOD_COUNT_EN.
- Defined:
  - Adds output PERIOD_COUNT [15:0].
  - Increments by 1 on each 1 -> 0 toggle of DIV_CLOCK (completed period).
  - Saturates at 16'hFFFF.
  - Cleared by reset and by each applied divide value.
  - Held when ENABLE = 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- DEFAULT_DIV = 0, reset released, ENABLE = 1 -> DIV_CLOCK toggles every cycle; TICK = 1 every 2nd cycle; first TICK one edge after ENABLE is sampled.
- DIV_LOAD with DIV_VALUE = 4 while idle, then ENABLE = 1 -> DIV_CLOCK high 5 cycles, low 5, period 10; TICK once per 10 cycles.
- Running with N = 4, DIV_LOAD DIV_VALUE = 1 mid high phase -> LOAD_PENDING = 1; current period finishes 5/5; the next period is 2/2; LOAD_PENDING clears at the 1 -> 0 edge.
- Two DIV_LOADs (values 7 then 3) within one period -> only N = 3 is applied; no N = 7 period is ever produced.
- DIV_LOAD coincident with the 1 -> 0 application edge -> the new value takes effect immediately; LOAD_PENDING stays 0.
- RESET_N = 0 for one cycle mid high phase, and separately ENABLE dropped mid-period -> both give DIV_CLOCK = 0 and COUNT = 0 next edge; reset restores DEFAULT_DIV, while ENABLE drop keeps the loaded N. With DIV_PERIOD_COUNT_EN, PERIOD_COUNT = 0 after reset.

Source files
------------

// File: rtl/clk_divider_prog_if.sv
// clk_divider_prog_if
//   Groups the run/load control and the divided outputs of clk_divider_prog.
//   Optional macro: DIV_PERIOD_COUNT_EN adds PERIOD_COUNT[15:0].
//   Signals:
//     ENABLE        controller -> divider  1 = run, 0 = hold idle
//     DIV_VALUE     controller -> divider  requested divide N (half-period N+1)
//     DIV_LOAD      controller -> divider  one-cycle capture strobe
//     DIV_CLOCK     divider -> controller  50% duty divided clock
//     TICK          divider -> controller  one-cycle pulse on DIV_CLOCK rise
//     LOAD_PENDING  divider -> controller  captured value awaiting application
//     PERIOD_COUNT  divider -> controller  completed periods (optional)
//   Modports: master (drives control), slave (the divider).
interface clk_divider_prog_if #(
  parameter int CNT_WIDTH = 26
);
  logic                 ENABLE;
  logic [CNT_WIDTH-1:0] DIV_VALUE;
  logic                 DIV_LOAD;
  logic                 DIV_CLOCK;
  logic                 TICK;
  logic                 LOAD_PENDING;
`ifdef DIV_PERIOD_COUNT_EN
  logic [15:0]          PERIOD_COUNT;

  modport master (
    output ENABLE, DIV_VALUE, DIV_LOAD,
    input  DIV_CLOCK, TICK, LOAD_PENDING, PERIOD_COUNT
  );
  modport slave (
    input  ENABLE, DIV_VALUE, DIV_LOAD,
    output DIV_CLOCK, TICK, LOAD_PENDING, PERIOD_COUNT
  );
`else
  modport master (
    output ENABLE, DIV_VALUE, DIV_LOAD,
    input  DIV_CLOCK, TICK, LOAD_PENDING
  );
  modport slave (
    input  ENABLE, DIV_VALUE, DIV_LOAD,
    output DIV_CLOCK, TICK, LOAD_PENDING
  );
`endif
endinterface

// File: rtl/clk_divider_prog.sv
// clk_divider_prog
//   Runtime-programmable clock divider. DIV_CLOCK has period 2*(N+1) CLOCK
//   cycles at 50% duty; TICK pulses for one cycle when DIV_CLOCK rises.
//   A new divide value is captured by DIV_LOAD and only applied on the
//   edge where DIV_CLOCK falls (or at the next edge while idle), so no
//   low/high pair ever mixes two divide values.
//   Optional macro: DIV_PERIOD_COUNT_EN adds a saturating PERIOD_COUNT.
//   Ports:
//     CLOCK    system clock, rising edge
//     RESET_N  synchronous active-low reset
//     bus      clk_divider_prog_if.slave (ENABLE, DIV_VALUE, DIV_LOAD,
//              DIV_CLOCK, TICK, LOAD_PENDING[, PERIOD_COUNT])
module clk_divider_prog #(
  parameter int CNT_WIDTH   = 26,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  clk_divider_prog_if.slave    bus
);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] active_q, active_d;
  logic [CNT_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                 div_clk_q, div_clk_d;
  logic                 tick_q, tick_d;
  logic                 pending_q, pending_d;
  logic                 apply_edge;
`ifdef DIV_PERIOD_COUNT_EN
  logic [15:0]          period_cnt_q, period_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  always_comb begin
    count_d    = count_q;
    active_d   = active_q;
    pend_val_d = pend_val_q;
    div_clk_d  = div_clk_q;
    tick_d     = 1'b0;
    pending_d  = pending_q;
    apply_edge = 1'b0;
`ifdef DIV_PERIOD_COUNT_EN
    period_cnt_d = period_cnt_q;
`endif

    if (bus.DIV_LOAD) begin
      pend_val_d = bus.DIV_VALUE;
      pending_d  = 1'b1;
    end

    if (bus.ENABLE) begin
      // Terminal compare wraps the counter, so N = all-ones never overflows.
      if (count_q == active_q) begin
        count_d    = '0;
        div_clk_d  = ~div_clk_q;
        tick_d     = ~div_clk_q;
        // The falling edge closes a low+high pair: safe point to switch N.
        apply_edge = div_clk_q;
`ifdef DIV_PERIOD_COUNT_EN
        if (div_clk_q) period_cnt_d = sat_inc16(period_cnt_q);
`endif
      end else begin
        count_d = count_q + CNT_WIDTH'(1);
      end
    end else begin
      count_d    = '0;
      div_clk_d  = 1'b0;
      // Idle: only an already-captured value makes this an application edge.
      apply_edge = pending_q;
    end

    // A load coinciding with an application edge bypasses the pending slot.
    if (apply_edge && (pending_q || bus.DIV_LOAD)) begin
      active_d  = bus.DIV_LOAD ? bus.DIV_VALUE : pend_val_q;
      pending_d = 1'b0;
      count_d   = '0;
`ifdef DIV_PERIOD_COUNT_EN
      period_cnt_d = 16'd0;
`endif
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      count_q    <= '0;
      active_q   <= CNT_WIDTH'(DEFAULT_DIV);
      pend_val_q <= '0;
      div_clk_q  <= 1'b0;
      tick_q     <= 1'b0;
      pending_q  <= 1'b0;
`ifdef DIV_PERIOD_COUNT_EN
      period_cnt_q <= 16'd0;
`endif
    end else begin
      count_q    <= count_d;
      active_q   <= active_d;
      pend_val_q <= pend_val_d;
      div_clk_q  <= div_clk_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
`ifdef DIV_PERIOD_COUNT_EN
      period_cnt_q <= period_cnt_d;
`endif
    end
  end

  assign bus.DIV_CLOCK    = div_clk_q;
  assign bus.TICK         = tick_q;
  assign bus.LOAD_PENDING = pending_q;
`ifdef DIV_PERIOD_COUNT_EN
  assign bus.PERIOD_COUNT = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog
//   Scoreboard bench for clk_divider_prog. Expected DIV_CLOCK phase lengths
//   (level + length in CLOCK cycles) are queued when a divide value is
//   programmed; a negedge monitor measures each completed phase and pops.
//   TICK is checked against observed DIV_CLOCK rises; reset, latency and
//   LOAD_PENDING are checked directly.
module tb_clk_divider_prog;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_divider_prog_if #(.CNT_WIDTH(CW)) bus ();

  clk_divider_prog #(.CNT_WIDTH(CW), .DEFAULT_DIV(0)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  bit          mon_en  = 1'b0;
  bit          tick_en = 1'b0;
  bit          started = 1'b0;
  logic        prev_lvl;
  int          run_len = 0;
  logic        prev_dc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] run_code(input logic lvl, input int len);
    return {15'd0, lvl, 16'(len)};
  endfunction

  task automatic push_run(input logic lvl, input int len);
    sb_q.push_back(run_code(lvl, len));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sb_empty(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step();
      if (sb_q.size() == 0) return;
    end
    check_eq(tag, sb_q.size(), 0);
  endtask

  task automatic wait_level(input logic lvl, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.DIV_CLOCK === lvl) return;
    end
    check_eq(tag, {31'd0, bus.DIV_CLOCK}, {31'd0, lvl});
  endtask

  // Phase-length monitor: a phase is scored only if its start was observed.
  always @(negedge clk) begin
    if (!mon_en) begin
      started  = 1'b0;
      run_len  = 0;
      prev_lvl = bus.DIV_CLOCK;
    end else if (bus.DIV_CLOCK === prev_lvl) begin
      run_len++;
    end else begin
      if (started && sb_q.size() > 0)
        check_eq("phase", run_code(prev_lvl, run_len), sb_q.pop_front());
      started  = 1'b1;
      run_len  = 1;
      prev_lvl = bus.DIV_CLOCK;
    end
  end

  // TICK must be high exactly in the first sampled cycle of each high phase.
  always @(negedge clk) begin
    if (tick_en && (bus.TICK === 1'b1 || (bus.DIV_CLOCK === 1'b1 && prev_dc === 1'b0)))
      check_eq("tick", {31'd0, bus.TICK}, {31'd0, (bus.DIV_CLOCK === 1'b1 && prev_dc === 1'b0)});
    prev_dc = bus.DIV_CLOCK;
  end

  initial begin
    rst_n         = 1'b0;
    bus.ENABLE    = 1'b0;
    bus.DIV_LOAD  = 1'b0;
    bus.DIV_VALUE = '0;
    repeat (3) step();
    check_eq("rst_dc",   {31'd0, bus.DIV_CLOCK},    32'd0);
    check_eq("rst_tick", {31'd0, bus.TICK},         32'd0);
    check_eq("rst_pend", {31'd0, bus.LOAD_PENDING}, 32'd0);
`ifdef DIV_PERIOD_COUNT_EN
    check_eq("rst_pcnt", {16'd0, bus.PERIOD_COUNT}, 32'd0);
`endif
    rst_n = 1'b1;
    step();
    tick_en = 1'b1;

    // Default N = 0: CLOCK/2, first high one edge after ENABLE sampled
    for (int i = 0; i < 3; i++) begin push_run(1'b1, 1); push_run(1'b0, 1); end
    mon_en     = 1'b1;
    bus.ENABLE = 1'b1;
    step();
    check_eq("lat0_dc",   {31'd0, bus.DIV_CLOCK}, 32'd1);
    check_eq("lat0_tick", {31'd0, bus.TICK},      32'd1);
    wait_sb_empty(20, "to_n0");
    mon_en     = 1'b0;
    bus.ENABLE = 1'b0;
    step();
    check_eq("idle_dc", {31'd0, bus.DIV_CLOCK}, 32'd0);

    // Load N = 4 while idle; applied on the following idle edge
    bus.DIV_LOAD  = 1'b1;
    bus.DIV_VALUE = 4'd4;
    step();
    bus.DIV_LOAD = 1'b0;
    check_eq("idle_pend_set", {31'd0, bus.LOAD_PENDING}, 32'd1);
    step();
    check_eq("idle_pend_clr", {31'd0, bus.LOAD_PENDING}, 32'd0);
    push_run(1'b1, 5); push_run(1'b0, 5);
    mon_en     = 1'b1;
    bus.ENABLE = 1'b1;
    wait_sb_empty(40, "to_n4");

    // Mid high phase: load N = 1; current high finishes at 5, then 2/2
    step();
    push_run(1'b1, 5); push_run(1'b0, 2); push_run(1'b1, 2); push_run(1'b0, 2);
    bus.DIV_LOAD  = 1'b1;
    bus.DIV_VALUE = 4'd1;
    step();
    bus.DIV_LOAD = 1'b0;
    check_eq("mid_pend_set", {31'd0, bus.LOAD_PENDING}, 32'd1);
    wait_level(1'b0, 20, "to_fall4");
    check_eq("mid_pend_clr", {31'd0, bus.LOAD_PENDING}, 32'd0);
    wait_sb_empty(30, "to_n1");

    // Two loads (7 then 3) inside one period: only N = 3 ever appears
    wait_level(1'b0, 10, "to_fall1");
    push_run(1'b0, 2); push_run(1'b1, 2);
    push_run(1'b0, 4); push_run(1'b1, 4); push_run(1'b0, 4);
    bus.DIV_LOAD  = 1'b1;
    bus.DIV_VALUE = 4'd7;
    step();
    bus.DIV_VALUE = 4'd3;
    step();
    bus.DIV_LOAD = 1'b0;
    check_eq("lastwin_pend", {31'd0, bus.LOAD_PENDING}, 32'd1);
    wait_sb_empty(40, "to_n3");

    // Load exactly on the falling (application) edge: N = 2 immediately
    push_run(1'b1, 4); push_run(1'b0, 3); push_run(1'b1, 3); push_run(1'b0, 3);
    repeat (3) step();
    bus.DIV_LOAD  = 1'b1;
    bus.DIV_VALUE = 4'd2;
    step();
    bus.DIV_LOAD = 1'b0;
    check_eq("coinc_pend", {31'd0, bus.LOAD_PENDING}, 32'd0);
    check_eq("coinc_dc",   {31'd0, bus.DIV_CLOCK},    32'd0);
    wait_sb_empty(40, "to_n2");

    // ENABLE dropped mid high phase; N = 2 retained on re-enable
    mon_en = 1'b0;
    step();
    bus.ENABLE = 1'b0;
    step();
    check_eq("drop_dc",   {31'd0, bus.DIV_CLOCK}, 32'd0);
    check_eq("drop_tick", {31'd0, bus.TICK},      32'd0);
    step();
    check_eq("drop_pend", {31'd0, bus.LOAD_PENDING}, 32'd0);
    push_run(1'b1, 3); push_run(1'b0, 3); push_run(1'b1, 3);
    mon_en     = 1'b1;
    bus.ENABLE = 1'b1;
    step();
    step();
    check_eq("re_lat_lo", {31'd0, bus.DIV_CLOCK}, 32'd0);
    step();
    check_eq("re_lat_hi", {31'd0, bus.DIV_CLOCK}, 32'd1);
    wait_sb_empty(30, "to_reen");

    // One-cycle reset mid high phase restores DEFAULT_DIV = 0
    wait_level(1'b1, 10, "to_rise2");
    step();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    step();
    check_eq("mrst_dc",   {31'd0, bus.DIV_CLOCK},    32'd0);
    check_eq("mrst_tick", {31'd0, bus.TICK},         32'd0);
    check_eq("mrst_pend", {31'd0, bus.LOAD_PENDING}, 32'd0);
`ifdef DIV_PERIOD_COUNT_EN
    check_eq("mrst_pcnt", {16'd0, bus.PERIOD_COUNT}, 32'd0);
`endif
    rst_n = 1'b1;
    push_run(1'b1, 1); push_run(1'b0, 1); push_run(1'b1, 1); push_run(1'b0, 1);
    mon_en = 1'b1;
    step();
    check_eq("mrst_default", {31'd0, bus.DIV_CLOCK}, 32'd1);
    wait_sb_empty(20, "to_def");

    // Maximum divide value: counter reaches all-ones and wraps by compare
    mon_en     = 1'b0;
    bus.ENABLE = 1'b0;
    step();
    bus.DIV_LOAD  = 1'b1;
    bus.DIV_VALUE = 4'd15;
    step();
    bus.DIV_LOAD = 1'b0;
    step();
    push_run(1'b1, 16); push_run(1'b0, 16); push_run(1'b1, 16);
    mon_en     = 1'b1;
    bus.ENABLE = 1'b1;
    wait_sb_empty(120, "to_max");
    mon_en = 1'b0;

    check_eq("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
